dmem_sram_responder: RTL and testbench
======================================

Name: dmem_sram_responder

Overview:
Memory-side responder for the load/store unit's word-aligned memory interface. It receives word address, write data, byte enables and read/write strobes, and serves them from a single-port SRAM macro with active-low chip and write selects, per-byte write mask and fixed read latency. It stalls the CPU pipeline until each access completes and flags accesses that fall outside its address window. It sits between the LSU and the data SRAM macro.

Parameters:
ADDR_WIDTH, 10, SRAM word-address bits (capacity 4*2^ADDR_WIDTH bytes)
BASE_ADDR, 32'h1000_0000, byte base address of window; multiple of window size
READ_LATENCY, 1, cycles from SRAM command edge until sram_dout valid (>=1)
WAIT_STATES, 0, extra stall cycles added to every access (>=0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
mem_addr  input  32  byte address from LSU, word-aligned ([1:0] ignored)
mem_wdata  input  32  lane-aligned write data
mem_be  input  4  byte enables, bit i = byte lane i
mem_we  input  1  write request
mem_re  input  1  read request
mem_rdata  output  32  full read word, lane alignment and sign extension done by LSU
mem_stall  output  1  CPU must hold request stable while high
mem_err  output  1  access out of window or illegal strobes
sram_csb  output  1  SRAM chip select, active-low
sram_web  output  1  SRAM write enable, active-low
sram_wmask  output  4  SRAM byte write mask
sram_addr  output  ADDR_WIDTH  SRAM word address
sram_din  output  32  SRAM write data
sram_dout  input  32  SRAM read data

Behaviour:
- Reset values: state IDLE, counter 0, mem_rdata 0, mem_stall 0, mem_err 0, sram_csb 1, sram_web 1, sram_wmask 0, sram_addr 0, sram_din 0.
- Request exists when mem_re or mem_we is high. In-window: BASE_ADDR <= mem_addr < BASE_ADDR + 4*2^ADDR_WIDTH. sram_addr = (mem_addr - BASE_ADDR)[ADDR_WIDTH+1:2].
- States: IDLE, WAIT, DONE.
- IDLE, no request: SRAM outputs at idle values, mem_stall 0.
- IDLE, error: out-of-window request, or mem_re and mem_we both high. mem_err 1 combinationally, mem_stall 0, no SRAM access, mem_rdata driven 0 that cycle. State stays IDLE.
- IDLE, write with mem_be==0: completes without SRAM access, no stall, no error.
- IDLE, valid write (cycle T0): combinationally drive sram_csb 0, sram_web 0, sram_wmask=mem_be, sram_din=mem_wdata, sram_addr.
  - WAIT_STATES==0: mem_stall 0; single cycle; stay IDLE.
  - Otherwise: mem_stall 1. If WAIT_STATES==1, go to DONE; else go to WAIT for WAIT_STATES-1 cycles, then DONE. Total WAIT_STATES+1 cycles.
- IDLE, valid read (T0): drive sram_csb 0, sram_web 1, sram_addr; mem_stall 1; go to WAIT. Counter counts cycles since T0.
  - Capture sram_dout into the rdata register at the end of cycle T0+READ_LATENCY.
  - Stay in WAIT through T0+READ_LATENCY+WAIT_STATES, then go to DONE.
  - DONE at T0+READ_LATENCY+WAIT_STATES+1. Total READ_LATENCY+WAIT_STATES+2 cycles.
- WAIT: mem_stall 1; SRAM outputs idle (sram_csb 1); request inputs ignored. The SRAM is commanded exactly once per access.
- DONE: mem_stall 0; mem_rdata = captured word; SRAM idle; unconditionally return to IDLE next cycle. A request seen in the following IDLE cycle is a new access.
- mem_rdata holds the last captured value outside error cycles.
- rst asserted in any state: at the next edge, state IDLE and all outputs return to reset values. An in-flight read is dropped, with no capture and no further SRAM command.
- mem_err is meaningful only in IDLE with a request present; it is 0 in WAIT and DONE.

Test Plan:
- Reset: hold rst 3 cycles with mem_re=1 -> mem_stall 0, sram_csb 1, mem_rdata 0 throughout.
- Word write then read, default params: write 0x1000_0010, data 0xDEADBEEF, be 1111 -> same cycle sram_csb 0, sram_web 0, sram_addr 4, sram_wmask 1111, mem_stall 0. Read 0x1000_0010 -> mem_stall 1 for 2 cycles, single sram_csb pulse, third cycle mem_stall 0, mem_rdata 0xDEADBEEF.
- Byte merge: after the previous scenario, write 0x1000_0012, data 0x00AB0000, be 0100 -> sram_wmask 0100. Word read of 0x1000_0010 returns 0xDEABBEEF.
- Errors: read 0x2000_0000 -> mem_err 1, mem_stall 0, sram_csb 1, mem_rdata 0. mem_re=mem_we=1 at 0x1000_0000 -> mem_err 1, no SRAM access.
- Wait states, WAIT_STATES=2, READ_LATENCY=1: read -> mem_stall high 4 cycles, data valid in cycle 5. Write -> mem_stall high 2 cycles, release in cycle 3. One SRAM command each.
- Reset mid-read: assert rst at T0+1 -> next cycle mem_stall 0, mem_rdata 0, no second sram_csb pulse. A fresh read afterwards completes normally.

Source files
------------

// File: rtl/dmem_sram_responder_if.sv
// rtl/dmem_sram_responder_if.sv - LSU-side word memory bus between load/store unit and data memory responder
interface dmem_sram_responder_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        mem_err;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_be,
        output mem_we,
        output mem_re,
        input  mem_rdata,
        input  mem_stall,
        input  mem_err
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        input  mem_we,
        input  mem_re,
        output mem_rdata,
        output mem_stall,
        output mem_err
    );
endinterface

// File: rtl/dmem_sram_responder.sv
// rtl/dmem_sram_responder.sv - serves LSU word accesses from a single-port SRAM with fixed read latency and stalls
module dmem_sram_responder #(
    parameter int          ADDR_WIDTH   = 10,
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          READ_LATENCY = 1,
    parameter int          WAIT_STATES  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_sram_responder_if.slave  mem,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [3:0]            sram_wmask,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_din,
    input  logic [31:0]           sram_dout
);

    localparam logic [32:0] WIN_SIZE = 33'(4) << ADDR_WIDTH;
    localparam int          RD_LAST  = READ_LATENCY + WAIT_STATES;
    localparam int          WR_LAST  = (WAIT_STATES > 1) ? WAIT_STATES - 1 : 1;
    localparam int          CW       = $clog2(RD_LAST + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_read;
    logic [31:0]     rdata_q;

    logic [31:0]     offset;
    logic            in_win;
    logic            has_req;
    logic            err_c;
    logic            rd_go;
    logic            wr_go;

    assign offset  = mem.mem_addr - BASE_ADDR;
    assign in_win  = (mem.mem_addr >= BASE_ADDR) && ({1'b0, offset} < WIN_SIZE);
    assign has_req = mem.mem_re | mem.mem_we;
    assign err_c   = (state == IDLE) && has_req && (!in_win || (mem.mem_re && mem.mem_we));
    assign rd_go   = (state == IDLE) && mem.mem_re && !mem.mem_we && in_win;
    assign wr_go   = (state == IDLE) && mem.mem_we && !mem.mem_re && in_win && (mem.mem_be != 4'b0000);

    // The SRAM is commanded only from IDLE so each access touches it exactly once;
    // reset forces idle values immediately so a held request cannot leak through.
    always_comb begin
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_wmask = 4'b0000;
        sram_addr  = '0;
        sram_din   = '0;
        mem.mem_stall = 1'b0;
        mem.mem_err   = 1'b0;
        if (!rst) begin
            if (rd_go) begin
                sram_csb  = 1'b0;
                sram_addr = offset[ADDR_WIDTH+1:2];
            end
            if (wr_go) begin
                sram_csb   = 1'b0;
                sram_web   = 1'b0;
                sram_wmask = mem.mem_be;
                sram_din   = mem.mem_wdata;
                sram_addr  = offset[ADDR_WIDTH+1:2];
            end
            mem.mem_stall = rd_go || (wr_go && (WAIT_STATES > 0)) || (state == WAIT);
            mem.mem_err   = err_c;
        end
    end

    assign mem.mem_rdata = (rst || err_c) ? 32'h0 : rdata_q;

    // cnt holds the number of cycles elapsed since the SRAM command cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            is_read <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rd_go) begin
                        state   <= WAIT;
                        cnt     <= CW'(1);
                        is_read <= 1'b1;
                    end else if (wr_go && (WAIT_STATES > 0)) begin
                        is_read <= 1'b0;
                        cnt     <= CW'(1);
                        if (WAIT_STATES == 1) begin
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (is_read && (cnt == CW'(READ_LATENCY))) begin
                        rdata_q <= sram_dout;
                    end
                    if (is_read ? (cnt == CW'(RD_LAST)) : (cnt == CW'(WR_LAST))) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_sram_responder.sv
// tb/tb_dmem_sram_responder.sv - randomized self-checking bench for two responder configurations
module tb_dmem_sram_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          WORDS = 1024;
    localparam int          RL = 1;

    logic        clk;
    logic        rst;
    int          sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic        re;

    logic        stall_a [2];
    logic        err_a   [2];
    logic [31:0] rdata_a [2];
    logic        csb_a   [2];
    logic        web_a   [2];
    logic [3:0]  wmask_a [2];
    logic [9:0]  saddr_a [2];
    logic [31:0] din_a   [2];
    int          ncmd_a  [2];

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [2][WORDS];
    logic [31:0] last_rd [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_sram_responder_if bus ();
        logic        csb, web;
        logic [3:0]  wmask;
        logic [9:0]  saddr;
        logic [31:0] din, dout;
        logic [31:0] smem [WORDS];
        bit          init_done = 1'b0;
        int          ncmd = 0;

        assign bus.mem_addr  = addr;
        assign bus.mem_wdata = wdata;
        assign bus.mem_be    = be;
        assign bus.mem_re    = (sel == g) ? re : 1'b0;
        assign bus.mem_we    = (sel == g) ? we : 1'b0;

        dmem_sram_responder #(
            .ADDR_WIDTH  (10),
            .BASE_ADDR   (BASE),
            .READ_LATENCY(RL),
            .WAIT_STATES ((g == 0) ? 0 : 2)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .mem       (bus),
            .sram_csb  (csb),
            .sram_web  (web),
            .sram_wmask(wmask),
            .sram_addr (saddr),
            .sram_din  (din),
            .sram_dout (dout)
        );

        // SRAM macro model: registered read, garbage on dout when not reading.
        always @(posedge clk) begin
            logic [31:0] w;
            if (!init_done) begin
                for (int i = 0; i < WORDS; i++) smem[i] = 32'h0;
                init_done = 1'b1;
            end
            if (!csb) begin
                ncmd = ncmd + 1;
                if (!web) begin
                    w = smem[saddr];
                    for (int b = 0; b < 4; b++)
                        if (wmask[b]) w[8*b +: 8] = din[8*b +: 8];
                    smem[saddr] = w;
                    dout <= $urandom;
                end else begin
                    dout <= smem[saddr];
                end
            end else begin
                dout <= $urandom;
            end
        end

        assign stall_a[g] = bus.mem_stall;
        assign err_a[g]   = bus.mem_err;
        assign rdata_a[g] = bus.mem_rdata;
        assign csb_a[g]   = csb;
        assign web_a[g]   = web;
        assign wmask_a[g] = wmask;
        assign saddr_a[g] = saddr;
        assign din_a[g]   = din;
        assign ncmd_a[g]  = ncmd;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int ws_of(input int s);
        return (s == 0) ? 0 : 2;
    endfunction

    function automatic bit in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(4 * WORDS));
    endfunction

    // One complete LSU access: drives request, checks every cycle until release.
    task automatic access(input int s, input bit w, input bit r,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        bit          is_err, is_acc;
        int          nst, c0, idx;
        logic [31:0] exp_rd, merged;
        is_err = (w && r) || !in_window(a);
        is_acc = !is_err && (r || (w && b != 4'b0000));
        idx    = int'((a - BASE) >> 2) % WORDS;
        if (is_err || !is_acc) nst = 0;
        else if (r) nst = RL + ws_of(s) + 1;
        else nst = ws_of(s);
        exp_rd = last_rd[s];
        if (!is_err && r) exp_rd = ref_mem[s][idx];
        if (is_acc && w) begin
            merged = ref_mem[s][idx];
            for (int i = 0; i < 4; i++)
                if (b[i]) merged[8*i +: 8] = d[8*i +: 8];
            ref_mem[s][idx] = merged;
        end
        sel = s; addr = a; wdata = d; be = b; we = w; re = r;
        c0 = ncmd_a[s];
        for (int k = 0; k <= nst; k++) begin
            @(negedge clk);
            chk("stall", 32'(stall_a[s]), 32'(k < nst));
            if (k == 0) begin
                chk("err", 32'(err_a[s]), 32'(is_err));
                chk("csb", 32'(csb_a[s]), 32'(!is_acc));
                if (is_acc) begin
                    chk("web", 32'(web_a[s]), 32'(r));
                    chk("sram_addr", 32'(saddr_a[s]), 32'(idx));
                    if (w) begin
                        chk("wmask", 32'(wmask_a[s]), 32'(b));
                        chk("din", din_a[s], d);
                    end
                end
            end else begin
                chk("err_busy", 32'(err_a[s]), 32'h0);
            end
            if (k == nst) chk("rdata", rdata_a[s], is_err ? 32'h0 : exp_rd);
        end
        @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0;
        chk("cmd_count", 32'(ncmd_a[s] - c0), 32'(is_acc));
        if (!is_err && r) last_rd[s] = exp_rd;
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  b;
        int          s, kind, c0;

        for (int i = 0; i < 2; i++) begin
            last_rd[i] = 32'h0;
            for (int j = 0; j < WORDS; j++) ref_mem[i][j] = 32'h0;
        end
        rst = 1'b1; sel = 0; addr = BASE; wdata = 32'h0; be = 4'hF; we = 1'b0; re = 1'b1;

        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("rst_stall", 32'(stall_a[i]), 32'h0);
                chk("rst_csb", 32'(csb_a[i]), 32'h1);
                chk("rst_rdata", rdata_a[i], 32'h0);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0; re = 1'b0;

        access(0, 1, 0, 32'h1000_0010, 32'hDEADBEEF, 4'b1111);
        access(0, 0, 1, 32'h1000_0010, 32'h0, 4'b0000);
        chk("word_read", rdata_a[0], 32'hDEADBEEF);
        access(0, 1, 0, 32'h1000_0012, 32'h00AB0000, 4'b0100);
        access(0, 0, 1, 32'h1000_0010, 32'h0, 4'b0000);
        chk("byte_merge", rdata_a[0], 32'hDEABBEEF);
        access(0, 0, 1, 32'h2000_0000, 32'h0, 4'b0000);
        access(0, 1, 1, 32'h1000_0000, 32'h1234_5678, 4'b1111);
        access(0, 1, 0, 32'h1000_0020, 32'h1111_2222, 4'b0000);
        access(0, 0, 1, 32'h1000_1000, 32'h0, 4'b0000);
        access(0, 0, 1, 32'h0FFF_FFFC, 32'h0, 4'b0000);

        access(1, 1, 0, 32'h1000_0008, 32'hCAFE_F00D, 4'b1111);
        access(1, 0, 1, 32'h1000_0008, 32'h0, 4'b0000);
        access(1, 1, 0, 32'h1000_0FFC, 32'hA5A5_5A5A, 4'b1001);
        access(1, 0, 1, 32'h1000_0FFC, 32'h0, 4'b0000);

        // Reset in the cycle after a read command drops the read.
        sel = 0; addr = 32'h1000_0010; re = 1'b1; we = 1'b0;
        c0 = ncmd_a[0];
        @(negedge clk);
        chk("mid_t0_stall", 32'(stall_a[0]), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; re = 1'b0;
        @(negedge clk);
        chk("mid_stall", 32'(stall_a[0]), 32'h0);
        chk("mid_rdata", rdata_a[0], 32'h0);
        chk("mid_csb", 32'(csb_a[0]), 32'h1);
        @(posedge clk);
        #1;
        chk("mid_cmd_count", 32'(ncmd_a[0] - c0), 32'h1);
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        access(0, 0, 1, 32'h1000_0010, 32'h0, 4'b0000);

        for (int n = 0; n < 80; n++) begin
            s    = $urandom_range(0, 1);
            kind = $urandom_range(0, 9);
            a    = BASE + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
            d    = $urandom;
            b    = 4'($urandom_range(0, 15));
            if (kind < 4) access(s, 0, 1, a, d, b);
            else if (kind < 8) access(s, 1, 0, a, d, b);
            else if (kind == 8) access(s, 1, 1, a, d, b);
            else access(s, $urandom_range(0, 1) == 1, 1'b1, BASE + 32'(4 * WORDS) + (a & 32'hFF), d, b);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("idle_stall", 32'(stall_a[s]), 32'h0);
                chk("idle_csb", 32'(csb_a[s]), 32'h1);
                @(posedge clk);
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
